// File: rtl/debounce_pkg.sv
// Shared constants and counter sizing for the switch debounce slice.
// MULTI_SWITCH_DEBOUNCE_SYNC_EN enables the per-channel input synchroniser.
package debounce_pkg;

  localparam int DEBOUNCE_LIMIT_DEF = 250000;
  localparam int CLK_HZ             = 25_000_000;

  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: optional synchroniser, debounce filter, edge pulses, toggle.
// MULTI_SWITCH_DEBOUNCE_SYNC_EN adds a two-flop synchroniser ahead of the filter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  input  logic i_Toggle_Clr,
  output logic o_Debounced,
  output logic o_Press,
  output logic o_Release,
  output logic o_Toggle
);

  localparam int CW = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_LIMIT - 1);

  logic smp;

`ifdef MULTI_SWITCH_DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) sync_q <= '0;
    else          sync_q <= {sync_q[0], i_Switch};
  end

  assign smp = sync_q[1];
`else
  assign smp = i_Switch;
`endif

  logic [CW-1:0] cnt;
  logic          q;
  logic          diff;
  logic          done;

  assign diff = smp ^ q;
  // done marks the LIMIT-th consecutive differing sample
  assign done = diff && (cnt == CMAX);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      q         <= 1'b0;
      cnt       <= '0;
      o_Press   <= 1'b0;
      o_Release <= 1'b0;
      o_Toggle  <= 1'b0;
    end else begin
      o_Press   <= done & smp;
      o_Release <= done & ~smp;
      if (!diff) begin
        cnt <= '0;
      end else if (done) begin
        q   <= smp;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (i_Toggle_Clr)      o_Toggle <= 1'b0;
      else if (done & ~smp)  o_Toggle <= ~o_Toggle;
    end
  end

  assign o_Debounced = q;

endmodule

// File: rtl/multi_switch_debounce.sv
// N-channel switch conditioner built from independent debounce_channel slices.
// MULTI_SWITCH_DEBOUNCE_SYNC_EN enables per-channel two-flop synchronisers.
module multi_switch_debounce
  import debounce_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic              i_Toggle_Clr,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Toggle
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_ch (
      .i_Clk       (i_Clk),
      .i_Rst_L     (i_Rst_L),
      .i_Switch    (i_Switch[n]),
      .i_Toggle_Clr(i_Toggle_Clr),
      .o_Debounced (o_Debounced[n]),
      .o_Press     (o_Press[n]),
      .o_Release   (o_Release[n]),
      .o_Toggle    (o_Toggle[n])
    );
  end

endmodule

// File: tb/tb_multi_switch_debounce.sv
// Self-checking bench for multi_switch_debounce: vector tables, corner sequences,
// and randomized traffic against a run-length reference model.
module tb_multi_switch_debounce;

  localparam int NCH = 4;
  localparam int LIM = 4;
`ifdef MULTI_SWITCH_DEBOUNCE_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif
  // edge index (capture edge = 0) on which an accepted level appears
  localparam int FE = LIM - 1 + DLY;

  typedef struct {
    logic [3:0] sw;
    logic       clr;
    logic [3:0] deb;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] tog;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] sw = '0;
  logic [3:0] deb, prs, rel, tog;

  always #5 clk = ~clk;

  multi_switch_debounce #(
    .NUM_CH(NCH),
    .DEBOUNCE_LIMIT(LIM)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Switch    (sw),
    .i_Toggle_Clr(clr),
    .o_Debounced (deb),
    .o_Press     (prs),
    .o_Release   (rel),
    .o_Toggle    (tog)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: sample pipeline plus run length of differing samples
  logic [3:0] p1, p2, mq, mp, mr, mt;
  int         run [NCH];

  task automatic m_reset();
    p1 = '0; p2 = '0; mq = '0; mp = '0; mr = '0; mt = '0;
    foreach (run[i]) run[i] = 0;
  endtask

  task automatic m_edge();
    logic [3:0] s;
    if (DLY == 2) begin
      s  = p2;
      p2 = p1;
      p1 = sw;
    end else begin
      s = sw;
    end
    mp = '0;
    mr = '0;
    for (int c = 0; c < NCH; c++) begin
      if (s[c] != mq[c]) begin
        run[c]++;
        if (run[c] == LIM) begin
          mq[c] = s[c];
          if (s[c]) mp[c] = 1'b1;
          else      mr[c] = 1'b1;
          run[c] = 0;
        end
      end else begin
        run[c] = 0;
      end
    end
    if (clr) mt = '0;
    else     mt = mt ^ mr;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] v);
    sw  = v;
    clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst deb", deb, 0);
    chk("rst prs", prs, 0);
    chk("rst rel", rel, 0);
    chk("rst tog", tog, 0);
    m_reset();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  vec_t tv[$];

  task automatic apply_tv(input string tag);
    for (int i = 0; i < tv.size(); i++) begin
      sw  = tv[i].sw;
      clr = tv[i].clr;
      tick();
      chk($sformatf("%s[%0d] deb", tag, i), deb, tv[i].deb);
      chk($sformatf("%s[%0d] prs", tag, i), prs, tv[i].prs);
      chk($sformatf("%s[%0d] rel", tag, i), rel, tv[i].rel);
      chk($sformatf("%s[%0d] tog", tag, i), tog, tv[i].tog);
    end
    clr = 1'b0;
  endtask

  initial begin
    vec_t v;

    // held-through-reset press accepted as fresh press
    do_reset(4'hF);
    tv.delete();
    for (int i = 0; i < FE + 4; i++) begin
      v.sw  = 4'hF;
      v.clr = 1'b0;
      v.deb = (i >= FE) ? 4'hF : 4'h0;
      v.prs = (i == FE) ? 4'hF : 4'h0;
      v.rel = 4'h0;
      v.tog = 4'h0;
      tv.push_back(v);
    end
    apply_tv("rstpress");

    // clean press then release on ch0
    do_reset(4'h0);
    tv.delete();
    for (int i = 0; i < 10 + FE + 3; i++) begin
      v.sw  = (i < 10) ? 4'h1 : 4'h0;
      v.clr = 1'b0;
      v.deb = (i >= FE && i < 10 + FE) ? 4'h1 : 4'h0;
      v.prs = (i == FE) ? 4'h1 : 4'h0;
      v.rel = (i == 10 + FE) ? 4'h1 : 4'h0;
      v.tog = (i >= 10 + FE) ? 4'h1 : 4'h0;
      tv.push_back(v);
    end
    apply_tv("clean");

    // clear coincident with release wins
    sw = 4'h1;
    repeat (FE + 2) tick();
    chk("clrpri pre deb", deb[0], 1);
    sw = 4'h0;
    repeat (FE) tick();
    chk("clrpri pre tog", tog[0], 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrpri rel", rel[0], 1);
    chk("clrpri tog", tog[0], 0);
    tick();
    chk("clrpri rel after", rel[0], 0);
    chk("clrpri tog after", tog[0], 0);

    // bounce rejection on ch1, then steady press
    do_reset(4'h0);
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        sw[1] = (k < 3);
        tick();
        chk($sformatf("bounce r%0d k%0d deb", r, k), deb[1], 0);
        chk($sformatf("bounce r%0d k%0d prs", r, k), prs[1], 0);
      end
    end
    sw[1] = 1'b1;
    for (int i = 0; i < FE + 2; i++) begin
      tick();
      chk($sformatf("steady[%0d] prs", i), prs[1], (i == FE));
      chk($sformatf("steady[%0d] deb", i), deb[1], (i >= FE));
    end

    // channel independence: ch2 pressed, ch3 bouncing
    do_reset(4'h0);
    for (int i = 0; i < FE + 4; i++) begin
      sw[2] = 1'b1;
      sw[3] = ((i % 3) != 2);
      tick();
      chk($sformatf("indep[%0d] prs2", i), prs[2], (i == FE));
      chk($sformatf("indep[%0d] ch3", i), {deb[3], prs[3]}, 0);
      chk($sformatf("indep[%0d] ch01", i),
          {deb[1:0], prs[1:0], rel[1:0], tog[1:0]}, 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 4) == 0) sw[c] = ~sw[c];
      clr = ($urandom_range(0, 29) == 0);
      tick();
      chk($sformatf("rnd[%0d] deb", i), deb, mq);
      chk($sformatf("rnd[%0d] prs", i), prs, mp);
      chk($sformatf("rnd[%0d] rel", i), rel, mr);
      chk($sformatf("rnd[%0d] tog", i), tog, mt);
    end
    clr = 1'b0;

    // async reset mid-count restarts the full latency
    do_reset(4'h0);
    sw = 4'h1;
    repeat (FE - 1) tick();
    chk("midrst pre deb", deb[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst deb", deb, 0);
    chk("midrst prs", prs, 0);
    m_reset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < FE + 2; i++) begin
      tick();
      chk($sformatf("midrst[%0d] prs", i), prs[0], (i == FE));
      chk($sformatf("midrst[%0d] deb", i), deb[0], (i >= FE));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
